// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Miss/redirect sequencer states.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MISS_WAIT = 2'd1,
    RESUME    = 2'd2
  } hz_state_e;

  // EX operand source selects.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Stage control vectors are packed {F, D, E, M, W}.
  localparam logic [4:0] STG_ALL  = 5'b11111;
  localparam logic [4:0] STG_NONE = 5'b00000;
  localparam logic [4:0] STG_FD   = 5'b11000;
  localparam logic [4:0] STG_DE   = 5'b01100;
  localparam logic [4:0] STG_D    = 5'b01000;
  localparam logic [4:0] STG_E    = 5'b00100;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller: register addresses and
// hazard sources in, seg-reg controls, forwarding selects and counters out.
interface hazard_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) ();

  logic [ADDR_W-1:0] reg1_src_ID;
  logic [ADDR_W-1:0] reg2_src_ID;
  logic [1:0]        src_reg_en_ID;
  logic [ADDR_W-1:0] reg1_src_EX;
  logic [ADDR_W-1:0] reg2_src_EX;
  logic [ADDR_W-1:0] reg_dest_EX;
  logic [ADDR_W-1:0] reg_dest_MEM;
  logic [ADDR_W-1:0] reg_dest_WB;
  logic              reg_write_en_MEM;
  logic              reg_write_en_WB;
  logic              mem_read_EX;
  logic              br_EX;
  logic              jalr_EX;
  logic              jal_ID;
  logic              miss_req;
  logic              miss_done;

  logic              bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic              flushF, flushD, flushE, flushM, flushW;
  logic [1:0]        op1_sel;
  logic [1:0]        op2_sel;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  // Pipeline / environment side.
  modport master (
    output reg1_src_ID, reg2_src_ID, src_reg_en_ID, reg1_src_EX, reg2_src_EX,
    output reg_dest_EX, reg_dest_MEM, reg_dest_WB, reg_write_en_MEM, reg_write_en_WB,
    output mem_read_EX, br_EX, jalr_EX, jal_ID, miss_req, miss_done,
    input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
    input  flushF, flushD, flushE, flushM, flushW,
    input  op1_sel, op2_sel, stall_cycles, flush_events
  );

  // Hazard controller side.
  modport slave (
    input  reg1_src_ID, reg2_src_ID, src_reg_en_ID, reg1_src_EX, reg2_src_EX,
    input  reg_dest_EX, reg_dest_MEM, reg_dest_WB, reg_write_en_MEM, reg_write_en_WB,
    input  mem_read_EX, br_EX, jalr_EX, jal_ID, miss_req, miss_done,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
    output flushF, flushD, flushE, flushM, flushW,
    output op1_sel, op2_sel, stall_cycles, flush_events
  );

endinterface

// File: rtl/fwd_sel.sv
// Forwarding select for one EX operand. The MEM result is younger than WB, so it
// wins when both match; writes to x0 are never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] rd_mem_i,
  input  logic              we_mem_i,
  input  logic [ADDR_W-1:0] rd_wb_i,
  input  logic              we_wb_i,
  output logic [1:0]        sel_o
);

  logic hit_mem, hit_wb;

  assign hit_mem = we_mem_i && (rd_mem_i != '0) && (rd_mem_i == src_i);
  assign hit_wb  = we_wb_i  && (rd_wb_i  != '0) && (rd_wb_i  == src_i);

  // Priority pick of the youngest matching producer.
  always_comb begin
    sel_o = FWD_REG;
    if (hit_mem) begin
      sel_o = FWD_MEM;
    end else if (hit_wb) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: seg-reg bubble/flush generation, EX forwarding
// selects, and a miss sequencer that replays redirects colliding with a cache miss.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise stall_cycles/flush_events read constant zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hz
);

  hz_state_e  state_q, state_d;
  logic       pend_q, pend_d;
  logic [4:0] bub, flsh;
  logic [4:0] rule_bub, rule_flsh;
  logic       rule_inc, flush_inc;
  logic       redirect, load_use;
  logic [1:0] sel1, sel2;

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_op1 (
    .src_i    (hz.reg1_src_EX),
    .rd_mem_i (hz.reg_dest_MEM),
    .we_mem_i (hz.reg_write_en_MEM),
    .rd_wb_i  (hz.reg_dest_WB),
    .we_wb_i  (hz.reg_write_en_WB),
    .sel_o    (sel1)
  );

  fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_op2 (
    .src_i    (hz.reg2_src_EX),
    .rd_mem_i (hz.reg_dest_MEM),
    .we_mem_i (hz.reg_write_en_MEM),
    .rd_wb_i  (hz.reg_dest_WB),
    .we_wb_i  (hz.reg_write_en_WB),
    .sel_o    (sel2)
  );

  assign redirect = hz.br_EX | hz.jalr_EX;
  assign load_use = hz.mem_read_EX && (hz.reg_dest_EX != '0) &&
                    ((hz.src_reg_en_ID[1] && (hz.reg1_src_ID == hz.reg_dest_EX)) ||
                     (hz.src_reg_en_ID[0] && (hz.reg2_src_ID == hz.reg_dest_EX)));

  // Normal-flow hazard rules: redirect > load-use > jal.
  always_comb begin
    rule_bub  = STG_NONE;
    rule_flsh = STG_NONE;
    rule_inc  = 1'b0;
    if (redirect) begin
      rule_flsh = STG_DE;
      rule_inc  = 1'b1;
    end else if (load_use) begin
      rule_bub  = STG_FD;
      rule_flsh = STG_E;
    end else if (hz.jal_ID) begin
      rule_flsh = STG_D;
      rule_inc  = 1'b1;
    end
  end

  // Miss sequencer next state and stage controls; reset forces every seg reg clear.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    bub       = STG_NONE;
    flsh      = STG_NONE;
    flush_inc = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.miss_req) begin
          bub     = STG_ALL;
          pend_d  = pend_q | redirect;
          state_d = MISS_WAIT;
        end else begin
          bub       = rule_bub;
          flsh      = rule_flsh;
          flush_inc = rule_inc;
        end
      end
      MISS_WAIT: begin
        bub    = STG_ALL;
        pend_d = pend_q | redirect;
        if (hz.miss_done) begin
          state_d = RESUME;
        end
      end
      RESUME: begin
        // miss_req is ignored here so the refilled access always retires.
        state_d = RUN;
        if (pend_q) begin
          flsh      = STG_DE;
          pend_d    = 1'b0;
          flush_inc = 1'b1;
        end else begin
          bub       = rule_bub;
          flsh      = rule_flsh;
          flush_inc = rule_inc;
        end
      end
      default: begin
        state_d = RUN;
        pend_d  = 1'b0;
      end
    endcase
    if (!rst_n) begin
      bub       = STG_NONE;
      flsh      = STG_ALL;
      flush_inc = 1'b0;
    end
  end

  // Sequencer state and pending-redirect flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign {hz.bubbleF, hz.bubbleD, hz.bubbleE, hz.bubbleM, hz.bubbleW} = bub;
  assign {hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW}      = flsh;
  assign hz.op1_sel = rst_n ? sel1 : FWD_REG;
  assign hz.op2_sel = rst_n ? sel2 : FWD_REG;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flushev_q;
  logic             stall_inc;

  assign stall_inc = |bub;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      flushev_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_inc && (flushev_q != '1)) begin
        flushev_q <= flushev_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flushev_q;
`else
  logic unused_flush_inc;
  assign unused_flush_inc = flush_inc;
  assign hz.stall_cycles  = '0;
  assign hz.flush_events  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// all checked each cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Reference model: "frozen" = waiting for refill, "resume" = first cycle after refill.
  bit          m_frozen, m_resume, m_pend;
  logic [31:0] m_stall, m_flush;

  hazard_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (hz.reg_write_en_MEM && hz.reg_dest_MEM != 0 && hz.reg_dest_MEM == src) return 2'b01;
    if (hz.reg_write_en_WB && hz.reg_dest_WB != 0 && hz.reg_dest_WB == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic idle();
    hz.reg1_src_ID = 0; hz.reg2_src_ID = 0; hz.src_reg_en_ID = 0;
    hz.reg1_src_EX = 0; hz.reg2_src_EX = 0; hz.reg_dest_EX = 0;
    hz.reg_dest_MEM = 0; hz.reg_dest_WB = 0;
    hz.reg_write_en_MEM = 0; hz.reg_write_en_WB = 0; hz.mem_read_EX = 0;
    hz.br_EX = 0; hz.jalr_EX = 0; hz.jal_ID = 0; hz.miss_req = 0; hz.miss_done = 0;
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic cycle(input string tag);
    logic [4:0] eb, ef;
    logic [1:0] e1, e2;
    logic [31:0] es, efl;
    bit redirect, lu, inc, n_frozen, n_resume, n_pend;
    #2;
    eb = 0; ef = 0; e1 = 0; e2 = 0; inc = 0;
    n_frozen = 0; n_resume = 0; n_pend = 0;
    if (!rst_n) begin
      ef = 5'b11111;
      m_frozen = 0; m_resume = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    end else begin
      redirect = hz.br_EX || hz.jalr_EX;
      lu = hz.mem_read_EX && hz.reg_dest_EX != 0 &&
           ((hz.src_reg_en_ID[1] && hz.reg1_src_ID == hz.reg_dest_EX) ||
            (hz.src_reg_en_ID[0] && hz.reg2_src_ID == hz.reg_dest_EX));
      n_frozen = m_frozen; n_pend = m_pend;
      if (m_frozen) begin
        eb = 5'b11111;
        if (redirect) n_pend = 1;
        if (hz.miss_done) begin n_frozen = 0; n_resume = 1; end
      end else if (hz.miss_req && !m_resume) begin
        eb = 5'b11111;
        if (redirect) n_pend = 1;
        n_frozen = 1;
      end else if (m_resume && m_pend) begin
        ef = 5'b01100; n_pend = 0; inc = 1;
      end else if (redirect) begin
        ef = 5'b01100; inc = 1;
      end else if (lu) begin
        eb = 5'b11000; ef = 5'b00100;
      end else if (hz.jal_ID) begin
        ef = 5'b01000; inc = 1;
      end
      e1 = ref_fwd(hz.reg1_src_EX);
      e2 = ref_fwd(hz.reg2_src_EX);
    end
`ifdef HAZARD_PERF_CNT_EN
    es = m_stall; efl = m_flush;
`else
    es = 0; efl = 0;
`endif
    chk({tag, ".bubble"}, 32'({hz.bubbleF, hz.bubbleD, hz.bubbleE, hz.bubbleM, hz.bubbleW}),
        32'(eb));
    chk({tag, ".flush"}, 32'({hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW}), 32'(ef));
    chk({tag, ".op1_sel"}, 32'(hz.op1_sel), 32'(e1));
    chk({tag, ".op2_sel"}, 32'(hz.op2_sel), 32'(e2));
    chk({tag, ".stall_cycles"}, hz.stall_cycles, es);
    chk({tag, ".flush_events"}, hz.flush_events, efl);
    @(posedge clk);
    m_frozen = n_frozen; m_resume = n_resume; m_pend = n_pend;
    if (rst_n) begin
      if (eb != 0 && m_stall != '1) m_stall++;
      if (inc && m_flush != '1) m_flush++;
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    m_frozen = 0; m_resume = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);

    // T1 reset and release
    cycle("t1.rst");
    cycle("t1.rst2");
    rst_n = 1'b1;
    cycle("t1.rel");
    chk("t1.flushD_rel", 32'(hz.flushD), 32'(0));

    // T2 forwarding priority and x0
    hz.reg_dest_MEM = 5; hz.reg_dest_WB = 5; hz.reg_write_en_MEM = 1; hz.reg_write_en_WB = 1;
    hz.reg1_src_EX = 5; hz.reg2_src_EX = 3;
    cycle("t2.mem");
    hz.reg_write_en_MEM = 0;
    cycle("t2.wb");
    hz.reg_dest_MEM = 0; hz.reg_dest_WB = 0; hz.reg_write_en_MEM = 1; hz.reg1_src_EX = 0;
    cycle("t2.x0");
    idle();

    // T3 load-use single-cycle stall, then disabled sources
    hz.mem_read_EX = 1; hz.reg_dest_EX = 7; hz.reg2_src_ID = 7; hz.src_reg_en_ID = 2'b01;
    cycle("t3.lu");
    idle();
    cycle("t3.after");
    hz.mem_read_EX = 1; hz.reg_dest_EX = 7; hz.reg2_src_ID = 7; hz.src_reg_en_ID = 2'b00;
    cycle("t3.noen");
    idle();

    // T4 redirect beats load-use and jal
    hz.br_EX = 1; hz.jal_ID = 1;
    hz.mem_read_EX = 1; hz.reg_dest_EX = 7; hz.reg1_src_ID = 7; hz.src_reg_en_ID = 2'b10;
    cycle("t4.prio");
    idle();
    hz.jal_ID = 1;
    cycle("t4.jal");
    idle();
    cycle("t4.idle");

    // T5 miss with colliding branch, replay on resume, miss_req ignored in resume
    hz.miss_req = 1; hz.br_EX = 1;
    cycle("t5.entry");
    hz.br_EX = 0;
    for (int i = 0; i < 3; i++) cycle($sformatf("t5.wait%0d", i));
    hz.miss_done = 1;
    cycle("t5.done");
    hz.miss_done = 0;
    cycle("t5.resume");
    hz.miss_req = 0;
    cycle("t5.run");
    chk("t5.flushE_run", 32'(hz.flushE), 32'(0));

    // T6 reset during a miss discards the pending redirect
    hz.miss_req = 1; hz.jalr_EX = 1;
    cycle("t6.entry");
    hz.jalr_EX = 0;
    cycle("t6.wait");
    rst_n = 1'b0;
    cycle("t6.rst");
    rst_n = 1'b1;
    hz.miss_req = 0;
    cycle("t6.rel");
    cycle("t6.run");
    chk("t6.flushD_norep", 32'(hz.flushD), 32'(0));

    // Random traffic with small address space to provoke collisions
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      hz.reg1_src_ID = 5'($urandom_range(0, 3));
      hz.reg2_src_ID = 5'($urandom_range(0, 3));
      hz.src_reg_en_ID = 2'($urandom_range(0, 3));
      hz.reg1_src_EX = 5'($urandom_range(0, 3));
      hz.reg2_src_EX = 5'($urandom_range(0, 3));
      hz.reg_dest_EX = 5'($urandom_range(0, 3));
      hz.reg_dest_MEM = 5'($urandom_range(0, 3));
      hz.reg_dest_WB = 5'($urandom_range(0, 3));
      hz.reg_write_en_MEM = 1'($urandom_range(0, 1));
      hz.reg_write_en_WB = 1'($urandom_range(0, 1));
      hz.mem_read_EX = ($urandom_range(0, 2) == 0);
      hz.br_EX = ($urandom_range(0, 7) == 0);
      hz.jalr_EX = ($urandom_range(0, 11) == 0);
      hz.jal_ID = ($urandom_range(0, 5) == 0);
      hz.miss_req = m_frozen ? 1'b1 : ($urandom_range(0, 7) == 0);
      hz.miss_done = ($urandom_range(0, 3) == 0);
      cycle($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
